sbox_lanes_pipe: RTL
====================

# sbox_lanes_pipe

Multi-lane, pipelined AES S-box unit. Substitutes LANES bytes per beat using the composite-field (Canright, normal-basis) S-box datapath. Registered valid/ready handshake on both sides, with a sideband tag carried alongside the data. Sits between the AES round-key/state controller and the SubBytes/key-expansion datapath of the OFB/GMAC core, replacing per-byte combinational S-box instances.

## Interface
Parameters:
- LANES, default 4: bytes substituted per beat; legal 1..16.
- TAG_W, default 4: width of the sideband tag carried with each beat; legal 1..16.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESETN  input  1  asynchronous, active-low reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  unit accepts the beat this cycle.
- in_data  input  8*LANES  input bytes; lane i is in_data[8i+7:8i].
- in_enc  input  1  1 = forward S-box, 0 = inverse S-box. Only meaningful with SBOX_INV_EN.
- in_tag  input  TAG_W  opaque sideband, returned unchanged.
- out_valid  output  1  output beat present.
- out_ready  input  1  consumer accepts the output beat.
- out_data  output  8*LANES  substituted bytes, lane-aligned with in_data.
- out_tag  output  TAG_W  tag of the beat on out_data.
- busy  output  1  at least one beat is in flight in either stage.

## Operation
- Two register stages:
  - S1: input basis change (with the affine step for the selected direction), followed by the select/invert mux. Registers the 8-bit composite-field operand per lane, plus the enc bit and the tag.
  - S2: GF(2^8) inversion via GF(2^4)/GF(2^2) normal-basis tower, then output basis change and the affine step for the selected direction. Registers the result bytes and the tag.
- Lanes are independent and identical. There is no cross-lane arithmetic.
- Each stage has a valid bit v1 / v2. Advance conditions:
  - adv2 = !v2 | out_ready.
  - adv1 = !v1 | adv2.
  - in_ready = adv1 (combinational from v1, v2, out_ready; no combinational path from in_valid).
- Stage updates:
  - When adv1: v1 <= in_valid; S1 payload loads only if in_valid.
  - When adv2: v2 <= v1; S2 payload loads only if v1.
  - Bubbles collapse, so a full pipe with out_ready high sustains 1 beat/cycle.
- out_valid = v2. out_data and out_tag are driven from S2 registers and hold stable while out_valid & !out_ready.
- busy = v1 | v2.
- A beat is not dropped or duplicated under any in_valid/out_ready pattern. Beats leave in acceptance order.

## Timing
- Reset values (asynchronous, while RESETN low):
  - v1 = v2 = 0, so out_valid = 0 and busy = 0.
  - out_data = 0, out_tag = 0, all S1 payload = 0.
  - in_ready = 1 once reset is applied (pipe empty).
- Latency: a beat accepted at edge N appears on out_valid after edge N+2 when not stalled, i.e. 2 cycles.
- Throughput: 1 beat/cycle. Any number of stall cycles on out_ready extends the latency by the same number of cycles.
- Stall with both stages full (out_ready = 0): in_ready = 0, all registers hold.
- Simultaneous out_ready and in_valid with both stages full: S2 hands off, S1 moves to S2, and the new beat enters S1 in the same edge.
- Reset asserted mid-operation: in-flight beats are discarded and no partial beat emerges after release. The first beat accepted after release produces correct data 2 cycles later.
- Critical path: S2 inversion plus output basis change. Synthesis target is 100 MHz on the SoC fabric at LANES = 16.

## Configuration
- SBOX_INV_EN defined:
  - Inverse S-box logic (input and output basis-change alternatives plus the select muxes) is compiled in.
  - in_enc is sampled per beat and travels with it through S1, so mixed-direction streams are supported beat by beat.
- SBOX_INV_EN undefined:
  - Only the forward path is built; in_enc is ignored and every beat gets the forward S-box.
  - Port list is unchanged.
  - Intended for the OFB/GMAC build, which only encrypts.

## Test plan
- Forward vector, LANES = 4, in_enc = 1, in_data = 0x53_01_10_00 -> 2 cycles later out_data = 0xED_7C_CA_63, out_tag equal to the input tag.
- Exhaustive: all 256 byte values in every lane, forward and (with SBOX_INV_EN) inverse, compared against the FIPS-197 tables. InvS(0x63) = 0x00, InvS(0xED) = 0x53, and S(InvS(x)) = x for all x.
- Back-to-back streaming: 64 consecutive beats with out_ready = 1 -> out_valid high for 64 consecutive cycles starting at cycle 2, with tags in order 0..63 mod 2^TAG_W.
- Backpressure: random out_ready at 30% duty with continuous in_valid -> no loss or duplication, out_data stable while stalled, in_ready = 0 whenever v1 & v2 & !out_ready.
- Mixed direction with SBOX_INV_EN, alternating in_enc 1/0 on data 0x00 -> outputs alternate 0x63 and 0x52 per lane. Same stimulus without SBOX_INV_EN -> all 0x63.
- Reset mid-flight: drop RESETN while both stages are valid -> out_valid and busy go 0 immediately, out_data = 0. After release, in_ready = 1 and no stale beat appears.

Source files
------------

// File: rtl/sbox_lanes_pipe.sv
// Two-stage, LANES-wide AES S-box built on the Canright normal-basis composite-field datapath.
// Define SBOX_INV_EN to compile in the inverse S-box, selected per beat by in_enc.
module sbox_lanes_pipe #(
  parameter int LANES = 4,
  parameter int TAG_W = 4
) (
  input  logic               CLK,
  input  logic               RESETN,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic               in_enc,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);

  function automatic logic [1:0] gf2_mul(input logic [1:0] a, input logic [1:0] b);
    logic abcd;
    abcd = ~((a[1] ^ a[0]) & (b[1] ^ b[0]));
    return {~(a[1] & b[1]) ^ abcd, ~(a[0] & b[0]) ^ abcd};
  endfunction

  // GF(2^2) multiply with the scaling by N folded in (used for the sum term of GF(2^4) mul)
  function automatic logic [1:0] gf2_mul_scl(input logic [1:0] a, input logic [1:0] b);
    logic t;
    t = ~(a[0] & b[0]);
    return {~((a[1] ^ a[0]) & (b[1] ^ b[0])) ^ t, ~(a[1] & b[1]) ^ t};
  endfunction

  function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
    logic [1:0] p;
    p = gf2_mul_scl(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]);
    return {gf2_mul(a[3:2], b[3:2]) ^ p, gf2_mul(a[1:0], b[1:0]) ^ p};
  endfunction

  function automatic logic [3:0] gf4_inv(input logic [3:0] x);
    logic [1:0] a, b, c, d;
    logic sa, sb;
    a  = x[3:2];
    b  = x[1:0];
    sa = a[1] ^ a[0];
    sb = b[1] ^ b[0];
    c  = {~(a[1] | b[1]) ^ ~(sa & sb), ~(sa | sb) ^ ~(a[0] & b[0])};
    d  = {c[0], c[1]};
    return {gf2_mul(d, b), gf2_mul(d, a)};
  endfunction

  // Inversion in GF(2^8)/GF(2^4): c is the merged (ab + (a+b)^2*nu) term, then d = c^-1
  function automatic logic [7:0] gf8_inv(input logic [7:0] x);
    logic [3:0] a, b, c, d;
    logic [1:0] sa, sb;
    logic al, ah, aa, bl, bh, bb, c1, c2, c3;
    a  = x[7:4];
    b  = x[3:0];
    sa = a[3:2] ^ a[1:0];
    sb = b[3:2] ^ b[1:0];
    al = a[1] ^ a[0];
    ah = a[3] ^ a[2];
    aa = sa[1] ^ sa[0];
    bl = b[1] ^ b[0];
    bh = b[3] ^ b[2];
    bb = sb[1] ^ sb[0];
    c1 = ~(ah & bh);
    c2 = ~(sa[0] & sb[0]);
    c3 = ~(aa & bb);
    c[3] = ~(sa[0] | sb[0]) ^ ~(a[3] & b[3]) ^ c1 ^ c3;
    c[2] = ~(sa[1] | sb[1]) ^ ~(a[2] & b[2]) ^ c1 ^ c2;
    c[1] = ~(al | bl) ^ ~(a[1] & b[1]) ^ c2 ^ c3;
    c[0] = ~(a[0] | b[0]) ^ ~(al & bl) ^ ~(sa[1] & sb[1]) ^ c2;
    d = gf4_inv(c);
    return {gf4_mul(d, b), gf4_mul(d, a)};
  endfunction

  function automatic logic [7:0] fwd_in(input logic [7:0] a);
    logic r1, r2, r3, r4, r5, r6, r7, r8, r9;
    r1 = a[7] ^ a[5];
    r2 = ~(a[7] ^ a[4]);
    r3 = a[6] ^ a[0];
    r4 = ~(a[5] ^ r3);
    r5 = a[4] ^ r4;
    r6 = a[3] ^ a[0];
    r7 = a[2] ^ r1;
    r8 = a[1] ^ r3;
    r9 = a[3] ^ r8;
    return ~{~(r7 ^ r8), r5, a[1] ^ r4, ~(r1 ^ r3), a[1] ^ r2 ^ r6, ~a[0], r4, ~(a[2] ^ r9)};
  endfunction

  function automatic logic [7:0] fwd_out(input logic [7:0] c);
    logic t1, t2, t3, t4, t5, t6, t7, t8, t9;
    t1 = c[7] ^ c[3];
    t2 = c[6] ^ c[4];
    t3 = c[6] ^ c[0];
    t4 = ~(c[5] ^ c[3]);
    t5 = ~(c[5] ^ t1);
    t6 = ~(c[5] ^ c[1]);
    t7 = ~(c[4] ^ t6);
    t8 = c[2] ^ t4;
    t9 = c[1] ^ t2;
    return ~{t4, t1, t3, t5, t2 ^ t5, t3 ^ t8, t7, t9};
  endfunction

`ifdef SBOX_INV_EN
  // Inverse direction: the affine inverse is merged into the input basis change
  function automatic logic [7:0] inv_in(input logic [7:0] a);
    logic r1, r2, r3, r4, r5, r6, r7, r8, r9;
    r1 = a[7] ^ a[5];
    r2 = ~(a[7] ^ a[4]);
    r3 = a[6] ^ a[0];
    r4 = ~(a[5] ^ r3);
    r5 = a[4] ^ r4;
    r6 = a[3] ^ a[0];
    r7 = a[2] ^ r1;
    r8 = a[1] ^ r3;
    r9 = a[3] ^ r8;
    return ~{r2, a[4] ^ r8, a[6] ^ a[4], r9, ~(a[6] ^ r2), r7, a[4] ^ r6, a[1] ^ r5};
  endfunction

  function automatic logic [7:0] inv_out(input logic [7:0] c);
    logic t1, t2, t3, t4, t5, t6, t7, t8, t9, t10;
    t1  = c[7] ^ c[3];
    t2  = c[6] ^ c[4];
    t3  = c[6] ^ c[0];
    t4  = ~(c[5] ^ c[3]);
    t5  = ~(c[5] ^ t1);
    t6  = ~(c[5] ^ c[1]);
    t7  = ~(c[4] ^ t6);
    t8  = c[2] ^ t4;
    t9  = c[1] ^ t2;
    t10 = t3 ^ t5;
    return ~{~(c[4] ^ c[1]), c[1] ^ t10, c[2] ^ t10, ~(c[6] ^ c[1]), t8 ^ t9, ~(c[7] ^ t7), t6, ~c[2]};
  endfunction
`endif

  logic               v1, v2, adv1, adv2;
  logic [8*LANES-1:0] s1_op, s1_next, s2_next;
  logic [TAG_W-1:0]   s1_tag;
`ifdef SBOX_INV_EN
  logic               s1_enc;
`else
  logic               unused_enc;
  assign unused_enc = in_enc;
`endif

  assign adv2      = ~v2 | out_ready;
  assign adv1      = ~v1 | adv2;
  assign in_ready  = adv1;
  assign out_valid = v2;
  assign busy      = v1 | v2;

  always_comb begin
    s1_next = '0;
    for (int i = 0; i < LANES; i++) begin
`ifdef SBOX_INV_EN
      s1_next[8*i +: 8] = in_enc ? fwd_in(in_data[8*i +: 8]) : inv_in(in_data[8*i +: 8]);
`else
      s1_next[8*i +: 8] = fwd_in(in_data[8*i +: 8]);
`endif
    end
  end

  always_comb begin
    s2_next = '0;
    for (int i = 0; i < LANES; i++) begin
`ifdef SBOX_INV_EN
      s2_next[8*i +: 8] = s1_enc ? fwd_out(gf8_inv(s1_op[8*i +: 8]))
                                 : inv_out(gf8_inv(s1_op[8*i +: 8]));
`else
      s2_next[8*i +: 8] = fwd_out(gf8_inv(s1_op[8*i +: 8]));
`endif
    end
  end

  // Payload registers load only with a valid beat so outputs hold while stalled or idle
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      s1_op    <= '0;
      s1_tag   <= '0;
      out_data <= '0;
      out_tag  <= '0;
`ifdef SBOX_INV_EN
      s1_enc   <= 1'b0;
`endif
    end else begin
      if (adv1) begin
        v1 <= in_valid;
        if (in_valid) begin
          s1_op  <= s1_next;
          s1_tag <= in_tag;
`ifdef SBOX_INV_EN
          s1_enc <= in_enc;
`endif
        end
      end
      if (adv2) begin
        v2 <= v1;
        if (v1) begin
          out_data <= s2_next;
          out_tag  <= s1_tag;
        end
      end
    end
  end

endmodule
